// File: rtl/audio_pdm_decoder.sv
// ---------------------------------------------------------------------------
// audio_pdm_decoder
//   Recovers WIDTH-bit unsigned samples from a 1-bit pulse-density stream by
//   counting ones over fixed windows of 2^WIDTH clocks (boxcar decimation).
//   Receive-side partner of the first-order delta-sigma DAC: for a constant
//   modulator input D every full window holds exactly D ones, so recovery is
//   exact regardless of where the window boundaries fall.
//
// Ports
//   clk          system clock, pdm_in sampled on every rising edge
//   rst          synchronous active-high reset
//   pdm_in       pulse-density input stream
//   data         recovered sample (held in a one-entry buffer)
//   valid        data holds an unconsumed result
//   ready        consumer accepts data on an edge with valid && ready
//   overrun      sticky: an unconsumed result was overwritten
//   clr_overrun  synchronous clear of overrun (a coincident set wins)
// ---------------------------------------------------------------------------
module audio_pdm_decoder #(
  parameter int WIDTH       = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pdm_in,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  input  logic             ready,
  output logic             overrun,
  input  logic             clr_overrun
);

  localparam logic [WIDTH-1:0] PHASE_LAST = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] PHASE_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             w_pdm_s;
  logic [WIDTH-1:0] r_phase;
  logic [WIDTH:0]   r_accum;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_sat;
  logic             w_win_end;
  logic             w_overrun_set;
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_overrun;

  // Input synchronizer; depth 0 passes the pin straight through.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_pdm_s = pdm_in;
    end else if (SYNC_STAGES == 1) begin : g_sync1
      logic r_sync;
      // Single-stage capture register.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_sync <= 1'b0;
        end else begin
          r_sync <= pdm_in;
        end
      end
      assign w_pdm_s = r_sync;
    end else begin : g_syncn
      logic [SYNC_STAGES-1:0] r_sync;
      // Multi-stage shift chain, oldest bit at the top.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_sync <= {SYNC_STAGES{1'b0}};
        end else begin
          r_sync <= {r_sync[SYNC_STAGES-2:0], pdm_in};
        end
      end
      assign w_pdm_s = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  assign w_sum         = r_accum + {{WIDTH{1'b0}}, w_pdm_s};
  assign w_win_end     = (r_phase == PHASE_LAST);
  // Overwrite only counts as overrun when the old result is not taken this edge.
  assign w_overrun_set = w_win_end && r_valid && !ready;

  // An all-ones window (count 2^WIDTH) does not fit in WIDTH bits: clamp it.
  always_comb begin
    w_sat = w_sum[WIDTH-1:0];
    if (w_sum[WIDTH]) begin
      w_sat = PHASE_LAST;
    end else begin
      w_sat = w_sum[WIDTH-1:0];
    end
  end

  // Window phase counter and ones accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= {WIDTH{1'b0}};
      r_accum <= {(WIDTH+1){1'b0}};
    end else begin
      r_phase <= r_phase + PHASE_ONE;
      if (w_win_end) begin
        // The next window's first bit is counted on the following edge.
        r_accum <= {(WIDTH+1){1'b0}};
      end else begin
        r_accum <= w_sum;
      end
    end
  end

  // One-entry result buffer with valid/ready handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= {WIDTH{1'b0}};
      r_valid <= 1'b0;
    end else if (w_win_end) begin
      r_data  <= w_sat;
      r_valid <= 1'b1;
    end else if (r_valid && ready) begin
      r_data  <= r_data;
      r_valid <= 1'b0;
    end else begin
      r_data  <= r_data;
      r_valid <= r_valid;
    end
  end

  // Sticky overrun flag; a new overrun event beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (w_overrun_set) begin
      r_overrun <= 1'b1;
    end else if (clr_overrun) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= r_overrun;
    end
  end

  assign data    = r_data;
  assign valid   = r_valid;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_audio_pdm_decoder.sv
module tb_audio_pdm_decoder;

  localparam int W  = 6;
  localparam int SS = 2;
  localparam int N  = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         pdm_in;
  logic [W-1:0] data;
  logic         valid;
  logic         ready;
  logic         overrun;
  logic         clr_overrun;

  int checks = 0;
  int errors = 0;

  // Scoreboard and reference state.
  int          q[$];
  int          mcount;
  int          mphase;
  logic        mov;
  logic [SS-1:0] dl;
  logic [W-1:0]  macc;
  int          last_data;

  audio_pdm_decoder #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .pdm_in(pdm_in), .data(data), .valid(valid),
    .ready(ready), .overrun(overrun), .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // First-order delta-sigma modulator reference: carry out of a W-bit accumulator.
  function automatic logic mod_bit(input int d);
    logic [W:0] s;
    s    = {1'b0, macc} + d[W:0];
    macc = s[W-1:0];
    return s[W];
  endfunction

  // One clock: drive at negedge, model the edge, check at next negedge.
  task automatic cycle(input logic b, input logic rdy, input logic clr);
    logic cnt;
    int   fin;
    logic set;
    rst = 1'b0; pdm_in = b; ready = rdy; clr_overrun = clr;
    if (rdy && q.size() > 0) begin
      chk("data", int'(data), q[0]);
      last_data = int'(data);
      void'(q.pop_front());
    end
    @(posedge clk);
    cnt    = dl[SS-1];
    dl     = {dl[SS-2:0], b};
    mcount = mcount + int'(cnt);
    set    = 1'b0;
    if (mphase == N-1) begin
      fin = (mcount > N-1) ? N-1 : mcount;
      if (q.size() > 0) begin
        void'(q.pop_back());
        set = 1'b1;
      end
      q.push_back(fin);
      mcount = 0;
    end
    if (set) mov = 1'b1;
    else if (clr) mov = 1'b0;
    mphase = (mphase + 1) % N;
    @(negedge clk);
    chk("valid", int'(valid), (q.size() > 0) ? 1 : 0);
    chk("overrun", int'(overrun), int'(mov));
  endtask

  task automatic do_reset();
    rst = 1'b1; pdm_in = 1'b0; ready = 1'b0; clr_overrun = 1'b0;
    @(posedge clk);
    q.delete(); mcount = 0; mphase = 0; mov = 1'b0; dl = '0;
    @(negedge clk);
    chk("rst_data", int'(data), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_overrun", int'(overrun), 0);
  endtask

  task automatic run_mod(input int d, input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(mod_bit(d), rdy, 1'b0);
  endtask

  task automatic run_const(input logic b, input int n);
    for (int i = 0; i < n; i++) cycle(b, 1'b1, 1'b0);
  endtask

  task automatic run_until(input int d, input logic rdy, input int ph);
    for (int i = 0; i < N && mphase != ph; i++) cycle(mod_bit(d), rdy, 1'b0);
  endtask

  initial begin
    int k;
    int sweep[5];
    sweep[0] = 0; sweep[1] = 1; sweep[2] = 32; sweep[3] = 62; sweep[4] = 63;
    macc = '0; last_data = -1;
    rst = 1'b1; pdm_in = 1'b0; ready = 1'b0; clr_overrun = 1'b0;
    @(negedge clk);
    do_reset();

    // Constant D=21, ready held high.
    run_mod(21, 5*N + 2, 1'b1);
    chk("d21", last_data, 21);

    // Saturation and all-zero input.
    run_const(1'b1, 3*N + 2);
    chk("sat63", last_data, 63);
    run_const(1'b0, 2*N + 2);
    chk("zero", last_data, 0);

    // Sweep of constant inputs.
    for (int s = 0; s < 5; s++) begin
      run_mod(sweep[s], 3*N + 2, 1'b1);
      chk("sweep", last_data, sweep[s]);
    end

    // Two window ends with ready low -> overwrite and overrun.
    run_until(21, 1'b1, 0);
    run_mod(21, 2*N, 1'b0);
    chk("ovr_set", int'(overrun), 1);
    chk("ovr_data", int'(data), 21);
    cycle(mod_bit(21), 1'b0, 1'b1);
    chk("ovr_clr", int'(overrun), 0);
    chk("ovr_clr_valid", int'(valid), 1);
    cycle(mod_bit(21), 1'b1, 1'b0);
    chk("take_drop", int'(valid), 0);

    // ready asserted exactly on a window-end edge.
    run_until(33, 1'b0, N-1);
    cycle(mod_bit(33), 1'b0, 1'b0);
    run_until(33, 1'b0, N-1);
    cycle(mod_bit(33), 1'b1, 1'b0);
    chk("edge_take_valid", int'(valid), 1);
    chk("edge_take_ovr", int'(overrun), 0);
    // Clear coincident with an overwrite: set wins.
    run_until(33, 1'b0, N-1);
    cycle(mod_bit(33), 1'b0, 1'b1);
    chk("set_wins", int'(overrun), 1);
    cycle(mod_bit(33), 1'b1, 1'b1);

    // Reset mid-window at phase 30 with D=40.
    run_mod(40, 2*N, 1'b1);
    run_until(40, 1'b1, 30);
    do_reset();
    k = 0;
    for (int i = 0; i < 100 && !valid; i++) begin
      cycle(mod_bit(40), 1'b1, 1'b0);
      k++;
    end
    chk("rst_first_valid", k, N);
    run_mod(40, 2*N + 2, 1'b1);
    chk("d40", last_data, 40);

    // Step from D=10 to D=50 mid-window.
    run_mod(10, 3*N, 1'b1);
    run_until(10, 1'b1, 17);
    chk("step_pre", last_data, 10);
    run_mod(50, 3*N + 2, 1'b1);
    chk("step_post", last_data, 50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
